// File: rtl/mclk_freq_monitor.sv
// rtl/mclk_freq_monitor.sv - ADC master clock frequency monitor
//
// Counts rising edges of MON_CLK over windows of WINDOW_CYCLES reference
// clocks. After each window it reports the count, whether the count is within
// [MIN_COUNT, MAX_COUNT], a lock indication and a sticky loss-of-lock fault.
//
// Optional build macro: MCLK_MON_IRQ_EN adds the IRQ output.
//
// Ports:
//   CLK            in   reference clock (fabric clock)
//   FABRIC_RESET_N in   asynchronous active-low reset
//   EN             in   monitor enable (level)
//   MON_CLK        in   monitored clock, asynchronous to CLK (must be < CLK/2)
//   CLEAR_FAULT    in   single-cycle pulse, clears FAULT (and IRQ)
//   COUNT          out  edge count of the last completed window
//   VALID          out  one-cycle pulse when COUNT/IN_RANGE update
//   IN_RANGE       out  last window count within [MIN_COUNT, MAX_COUNT]
//   LOCKED         out  LOCK_WINDOWS consecutive in-range windows seen
//   FAULT          out  sticky: out-of-range window occurred while LOCKED
//   IRQ            out  (MCLK_MON_IRQ_EN only) LOCKED changed; held until CLEAR_FAULT
module mclk_freq_monitor #(
  parameter int WINDOW_CYCLES = 10000,
  parameter int MIN_COUNT     = 973,
  parameter int MAX_COUNT     = 993,
  parameter int LOCK_WINDOWS  = 4,
  parameter int CNT_W         = 16
) (
  input  logic             CLK,
  input  logic             FABRIC_RESET_N,
  input  logic             EN,
  input  logic             MON_CLK,
  input  logic             CLEAR_FAULT,
  output logic [CNT_W-1:0] COUNT,
  output logic             VALID,
  output logic             IN_RANGE,
  output logic             LOCKED,
  output logic             FAULT
`ifdef MCLK_MON_IRQ_EN
  ,
  output logic             IRQ
`endif
);

  localparam int WIN_W  = (WINDOW_CYCLES > 2) ? $clog2(WINDOW_CYCLES) : 1;
  localparam int GOOD_W = $clog2(LOCK_WINDOWS + 1);

  localparam logic [WIN_W-1:0]  WIN_LAST  = WIN_W'(WINDOW_CYCLES - 1);
  localparam logic [CNT_W-1:0]  CNT_MAX   = '1;
  localparam logic [CNT_W-1:0]  MIN_C     = CNT_W'(MIN_COUNT);
  localparam logic [CNT_W-1:0]  MAX_C     = CNT_W'(MAX_COUNT);
  localparam logic [GOOD_W-1:0] GOOD_LOCK = GOOD_W'(LOCK_WINDOWS);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    MEASURE = 2'd1,
    EVAL    = 2'd2
  } state_t;

  state_t            state;
  logic              sync1, sync2, sync3;
  logic              edge_q;
  logic [WIN_W-1:0]  win_cnt;
  logic [CNT_W-1:0]  edge_cnt;
  logic [GOOD_W-1:0] good_cnt;

  logic              cnt_in_range;
  logic [GOOD_W-1:0] good_inc;
  logic [CNT_W-1:0]  edge_cnt_inc;
  logic              eval_now;
  logic              fault_set;
  logic              lock_rise;
  logic              lock_fall;

  // Two-flop synchronizer followed by a registered rising-edge detector: an
  // edge sampled at cycle n is counted by the edge counter at cycle n+3.
  always_ff @(posedge CLK or negedge FABRIC_RESET_N) begin
    if (!FABRIC_RESET_N) begin
      sync1  <= 1'b0;
      sync2  <= 1'b0;
      sync3  <= 1'b0;
      edge_q <= 1'b0;
    end else begin
      sync1  <= MON_CLK;
      sync2  <= sync1;
      sync3  <= sync2;
      edge_q <= sync2 & ~sync3;
    end
  end

  always_comb begin
    cnt_in_range = (edge_cnt >= MIN_C) && (edge_cnt <= MAX_C);
    good_inc     = (good_cnt == GOOD_LOCK) ? GOOD_LOCK : good_cnt + GOOD_W'(1);
    edge_cnt_inc = (edge_q && (edge_cnt != CNT_MAX)) ? edge_cnt + CNT_W'(1) : edge_cnt;
    // EN low overrides everything, including a pending evaluation.
    eval_now     = EN && (state == EVAL);
    fault_set    = eval_now && !cnt_in_range && LOCKED;
    lock_rise    = eval_now && cnt_in_range && (good_inc == GOOD_LOCK) && !LOCKED;
    lock_fall    = LOCKED && (!EN || (eval_now && !cnt_in_range));
  end

  always_ff @(posedge CLK or negedge FABRIC_RESET_N) begin
    if (!FABRIC_RESET_N) begin
      state    <= IDLE;
      win_cnt  <= '0;
      edge_cnt <= '0;
      good_cnt <= '0;
      COUNT    <= '0;
      VALID    <= 1'b0;
      IN_RANGE <= 1'b0;
      LOCKED   <= 1'b0;
      FAULT    <= 1'b0;
    end else begin
      VALID <= 1'b0;
      // A fault raised this cycle beats a simultaneous clear.
      FAULT <= fault_set | (FAULT & ~CLEAR_FAULT);

      if (!EN) begin
        state    <= IDLE;
        LOCKED   <= 1'b0;
        good_cnt <= '0;
      end else begin
        case (state)
          IDLE: begin
            state    <= MEASURE;
            win_cnt  <= '0;
            edge_cnt <= '0;
          end
          MEASURE: begin
            edge_cnt <= edge_cnt_inc;
            if (win_cnt == WIN_LAST) begin
              state <= EVAL;
            end else begin
              win_cnt <= win_cnt + WIN_W'(1);
            end
          end
          EVAL: begin
            COUNT    <= edge_cnt;
            IN_RANGE <= cnt_in_range;
            VALID    <= 1'b1;
            if (cnt_in_range) begin
              good_cnt <= good_inc;
              if (good_inc == GOOD_LOCK) begin
                LOCKED <= 1'b1;
              end
            end else begin
              good_cnt <= '0;
              LOCKED   <= 1'b0;
            end
            // Any edge detected during this cycle is intentionally dropped.
            state    <= MEASURE;
            win_cnt  <= '0;
            edge_cnt <= '0;
          end
          default: begin
            state <= IDLE;
          end
        endcase
      end
    end
  end

`ifdef MCLK_MON_IRQ_EN
  // Any LOCKED transition raises IRQ; a new event beats a simultaneous clear.
  always_ff @(posedge CLK or negedge FABRIC_RESET_N) begin
    if (!FABRIC_RESET_N) begin
      IRQ <= 1'b0;
    end else begin
      IRQ <= lock_rise | lock_fall | (IRQ & ~CLEAR_FAULT);
    end
  end
`else
  logic unused_irq_terms;
  assign unused_irq_terms = lock_rise ^ lock_fall;
`endif

endmodule
